add_pipe: RTL and testbench

- Parametrised, pipelined add/subtract unit that replaces the fixed 16/32-bit adders on timing-critical datapaths.
- Splits a WIDTH-bit operation into SEG-bit segments, one segment per pipeline stage, with the carry registered between stages.
- Uses a valid/ready handshake on both sides with full backpressure.
- Produces the sum, carry-out, signed overflow and zero flags.

---
 rtl/add_pipe_if.sv | 30 +++
 rtl/add_pipe.sv | 130 +++++++++++++
 tb/tb_add_pipe.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_pipe_if.sv
`timescale 1ns/1ps
// add_pipe_if: operand and result handshake bundle for the add_pipe unit.
// The master drives operands and out_ready; the slave (the adder) answers with
// in_ready and the registered result with its flags.
interface add_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c0;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, c0, sub, out_ready,
    input  in_ready, out_valid, out, carry, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, c0, sub, out_ready,
    output in_ready, out_valid, out, carry, ovf, zero
  );
endinterface

// File: rtl/add_pipe.sv
`timescale 1ns/1ps
// add_pipe: pipelined add/subtract that resolves SEG bits per stage.
// Each stage adds one segment of the skewed operands plus the carry registered
// by the previous stage; finished low segments ride along unchanged. The stall
// is global: when the output is held, every stage holds.
module add_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic      clk,
  input  logic      rst,
  add_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0 || STAGES < 1 || STAGES > 16) begin : g_bad_param
    $error("add_pipe: WIDTH must be a multiple of SEG with 1..16 stages");
  end

  // Stage outputs, indexed by stage; the last entry is the visible result.
  logic [WIDTH-1:0] a_s [STAGES];
  logic [WIDTH-1:0] b_s [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             c_s [STAGES];
  logic             v_s [STAGES];
  logic             ovf_q;
  logic             zero_q;
  logic             adv;
  logic             unused_tail;

  // The whole pipe moves whenever the output slot is empty or being drained.
  assign adv          = !v_s[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv && !rst;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic             c_in;
    logic             v_in;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             c_q;
    logic             v_q;

    if (gi == 0) begin : g_head
      // Subtract is a + ~b + 1: invert b once here so later stages only add.
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign c_in = bus.sub | bus.c0;
      assign r_in = '0;
      assign v_in = bus.in_valid;
    end else begin : g_body
      assign a_in = a_s[gi-1];
      assign b_in = b_s[gi-1];
      assign c_in = c_s[gi-1];
      assign r_in = r_s[gi-1];
      assign v_in = v_s[gi-1];
    end

    assign seg_sum = {1'b0, a_in[gi*SEG +: SEG]}
                   + {1'b0, b_in[gi*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_in};

    // Splice this stage's segment into the partial result from upstream.
    always_comb begin
      r_d                = r_in;
      r_d[gi*SEG +: SEG] = seg_sum[SEG-1:0];
    end

    // Stage register: shift on adv; bubbles leave the data fields untouched.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        if (v_in) begin
          a_q <= a_in;
          b_q <= b_in;
          r_q <= r_d;
          c_q <= seg_sum[SEG];
        end
      end
    end

    assign a_s[gi] = a_q;
    assign b_s[gi] = b_q;
    assign r_s[gi] = r_q;
    assign c_s[gi] = c_q;
    assign v_s[gi] = v_q;

    if (gi == STAGES - 1) begin : g_tail
      logic msb_cin;
      logic ovf_d;
      logic zero_d;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      assign msb_cin = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ seg_sum[SEG-1];
      assign ovf_d   = msb_cin ^ seg_sum[SEG];
      assign zero_d  = (r_d == '0);

      // Flags are captured alongside the final result and held otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv && v_in) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  // The last stage's operand copies have no consumer.
  assign unused_tail = ^{a_s[STAGES-1], b_s[STAGES-1]};

  assign bus.out_valid = v_s[STAGES-1];
  assign bus.out       = r_s[STAGES-1];
  assign bus.carry     = c_s[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_add_pipe.sv
`timescale 1ns/1ps
// tb_add_pipe: directed and randomized checks of add_pipe against an
// arithmetic reference model, on a 32/8 instance and two 16-bit instances.
module tb_add_pipe;
  typedef struct packed {
    logic [31:0] res;
    logic        cy;
    logic        ov;
    logic        zr;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   sweep_go = 1'b0;
  bit   sweep_done [2];

  always #5 clk = ~clk;

  add_pipe_if #(.WIDTH(32)) bus0 ();
  add_pipe #(.WIDTH(32), .SEG(8)) u_dut (.clk(clk), .rst(rst), .bus(bus0));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values.
  function automatic res_t ref_op(input int w, input longint a, input longint b,
                                  input bit c0, input bit sub);
    longint m, half, sa, sb, sres, ures;
    res_t   r;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (sub) begin
      ures = (a - b + m) % m;
      r.cy = (a >= b);
      sres = sa - sb;
    end else begin
      ures = a + b + longint'(c0);
      r.cy = (ures >= m);
      ures = ures % m;
      sres = sa + sb + longint'(c0);
    end
    r.res = 32'(ures);
    r.ov  = (sres >= half) || (sres < -half);
    r.zr  = (ures == 0);
    return r;
  endfunction

  task automatic run_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit c0, input bit sub, input res_t want);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    bus0.a = a; bus0.b = b; bus0.c0 = c0; bus0.sub = sub;
    bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (bus0.out_valid) lat = i;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_result"}, 64'({bus0.out, bus0.carry, bus0.ovf, bus0.zero}), 64'(want));
    $display("[TB] %s a=%h b=%h c0=%0d sub=%0d -> out=%h carry=%0d ovf=%0d zero=%0d lat=%0d",
             tag, a, b, c0, sub, bus0.out, bus0.carry, bus0.ovf, bus0.zero, lat);
  endtask

  task automatic run_backpressure();
    res_t        exp_q [$];
    res_t        e;
    int          sent = 0;
    int          got = 0;
    int          dup = 0;
    bit          have = 1'b0;
    bit          prev_stall = 1'b0;
    logic [34:0] prev_out = '0;
    logic [34:0] cur;
    for (int t = 0; t < 300 && got < 10; t++) begin
      @(posedge clk); #1;
      if (!have && sent < 10) begin
        bus0.a = $urandom; bus0.b = $urandom;
        bus0.c0 = 1'($urandom_range(1)); bus0.sub = 1'($urandom_range(1));
        have = 1'b1;
      end
      bus0.in_valid  = have;
      bus0.out_ready = (t % 3 == 0);
      @(negedge clk);
      cur = {bus0.out, bus0.carry, bus0.ovf, bus0.zero};
      check("bp_in_ready", 64'(bus0.in_ready), 64'(!(bus0.out_valid && !bus0.out_ready)));
      if (prev_stall) begin
        check("bp_hold_valid", 64'(bus0.out_valid), 64'd1);
        check("bp_hold_data", 64'(cur), 64'(prev_out));
      end
      if (bus0.out_valid && bus0.out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_spurious", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("bp_result", 64'(cur), 64'(e));
          got++;
          $display("[TB] bp beat %0d -> out=%h carry=%0d ovf=%0d zero=%0d",
                   got, bus0.out, bus0.carry, bus0.ovf, bus0.zero);
        end
      end
      if (bus0.in_valid && bus0.in_ready) begin
        exp_q.push_back(ref_op(32, longint'(bus0.a), longint'(bus0.b), bus0.c0, bus0.sub));
        sent++;
        have = 1'b0;
      end
      prev_stall = bus0.out_valid && !bus0.out_ready;
      prev_out   = cur;
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    check("bp_beats", 64'(got), 64'd10);
    repeat (8) begin
      @(negedge clk);
      if (bus0.out_valid) dup++;
    end
    check("bp_no_dup", 64'(dup), 64'd0);
  endtask

  task automatic run_midflight_reset();
    int stale = 0;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus0.a = 32'h100 + 32'(i); bus0.b = 32'h1; bus0.c0 = 1'b0; bus0.sub = 1'b0;
      bus0.in_valid = 1'b1;
      @(negedge clk);
      check("mr_accept", 64'(bus0.in_ready), 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mr_in_ready_pre", 64'(bus0.in_ready), 64'd0);
    @(posedge clk); #1;
    check("mr_out_valid", 64'(bus0.out_valid), 64'd0);
    check("mr_out", 64'(bus0.out), 64'd0);
    check("mr_in_ready", 64'(bus0.in_ready), 64'd0);
    rst = 1'b0;
    bus0.in_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus0.out_valid) stale++;
    end
    check("mr_no_stale", 64'(stale), 64'd0);
    run_beat("mr_new", 32'h10, 32'h20, 1'b0, 1'b0, res_t'{32'h30, 1'b0, 1'b0, 1'b0});
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SW_SEG = (gi == 0) ? 4 : 16;
    localparam int SW_STG = 16 / SW_SEG;

    add_pipe_if #(.WIDTH(16)) sbus ();
    add_pipe #(.WIDTH(16), .SEG(SW_SEG)) u_sweep (.clk(clk), .rst(rst), .bus(sbus));

    initial begin : g_drv
      res_t        exp_q [$];
      int          cyc_q [$];
      int          stall_q [$];
      res_t        e;
      int          sent, got, stalls, lat, acc_c, acc_s;
      bit          have;
      logic [18:0] cur;
      sent = 0; got = 0; stalls = 0; have = 1'b0;
      sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0;
      sbus.c0 = 1'b0; sbus.sub = 1'b0; sbus.out_ready = 1'b1;
      wait (sweep_go);
      for (int t = 0; t < 10000 && got < 1000; t++) begin
        @(posedge clk); #1;
        if (!have && sent < 1000 && $urandom_range(3) != 0) begin
          sbus.a = 16'($urandom); sbus.b = 16'($urandom);
          sbus.c0 = 1'($urandom_range(1)); sbus.sub = 1'($urandom_range(1));
          have = 1'b1;
        end
        sbus.in_valid  = have;
        sbus.out_ready = (sent < 500) ? 1'b1 : ($urandom_range(3) != 0);
        @(negedge clk);
        cur = {sbus.out, sbus.carry, sbus.ovf, sbus.zero};
        if (sbus.out_valid && sbus.out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("sw%0d_spurious", SW_SEG), 64'(exp_q.size()), 64'd1);
          end else begin
            e     = exp_q.pop_front();
            acc_c = cyc_q.pop_front();
            acc_s = stall_q.pop_front();
            lat   = t - acc_c - (stalls - acc_s);
            check($sformatf("sw%0d_result", SW_SEG), 64'(cur), 64'(e));
            check($sformatf("sw%0d_lat", SW_SEG), 64'(lat), 64'(SW_STG));
            got++;
            $display("[TB] seg%0d beat %0d -> out=%h carry=%0d ovf=%0d zero=%0d lat=%0d",
                     SW_SEG, got, sbus.out, sbus.carry, sbus.ovf, sbus.zero, lat);
          end
        end
        if (sbus.in_valid && sbus.in_ready) begin
          exp_q.push_back(ref_op(16, longint'(sbus.a), longint'(sbus.b), sbus.c0, sbus.sub));
          cyc_q.push_back(t);
          stall_q.push_back(stalls);
          sent++;
          have = 1'b0;
        end
        if (sbus.out_valid && !sbus.out_ready) stalls++;
      end
      sbus.in_valid = 1'b0;
      check($sformatf("sw%0d_beats", SW_SEG), 64'(got), 64'd1000);
      sweep_done[gi] = 1'b1;
    end
  end

  initial begin : main
    int wait_cyc;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0;
    bus0.c0 = 1'b0; bus0.sub = 1'b0; bus0.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus0.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_flags", 64'({bus0.out, bus0.carry, bus0.ovf, bus0.zero}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_beat("add_small", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, res_t'{32'h0000_0003, 1'b0, 1'b0, 1'b0});
    run_beat("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, res_t'{32'h0000_0000, 1'b1, 1'b0, 1'b1});
    run_beat("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, res_t'{32'h8000_0000, 1'b0, 1'b1, 1'b0});
    run_beat("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, res_t'{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});

    run_backpressure();
    run_midflight_reset();

    sweep_go = 1'b1;
    wait_cyc = 0;
    while (!(sweep_done[0] && sweep_done[1]) && wait_cyc < 30000) begin
      @(posedge clk);
      wait_cyc++;
    end
    check("sweep_done", 64'({sweep_done[0], sweep_done[1]}), 64'd3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
